// File: rtl/timer_apb_regs_if.sv
// APB3 bus bundle between the system fabric (master) and the timer register block (slave).
// The bus has no clock or reset of its own; those stay plain ports on the completer.
interface timer_apb_regs_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [CNT_W-1:0]  pwdata;
    logic [CNT_W-1:0]  prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/timer_apb_regs.sv
// APB3 completer holding TDR/TCR/TSR/TCNT plus the prescaled 8-bit up/down counter with sticky wrap flags.
// Zero wait states: reads are combinational in the access phase, writes commit on that edge, pready tied high.
module timer_apb_regs #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic            pclk,
    input  logic            presetn,
    timer_apb_regs_if.slave apb,
    output logic            tmr_ovf,
    output logic            tmr_udf
);
    localparam logic [1:0]       A_TDR    = 2'd0;
    localparam logic [1:0]       A_TCR    = 2'd1;
    localparam logic [1:0]       A_TSR    = 2'd2;
    localparam logic [1:0]       A_TCNT   = 2'd3;
    localparam logic [CNT_W-1:0] TCR_MASK = CNT_W'(8'hB3);

    logic [CNT_W-1:0] tdr_q, tdr_d;
    logic [CNT_W-1:0] tcr_q, tcr_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [1:0]       tsr_q, tsr_d;
    logic [3:0]       presc_q, presc_d;
    logic [3:0]       presc_max;
    logic [CNT_W-1:0] rd_mux;

    logic       access;
    logic       addr_ok;
    logic       wr_commit;
    logic [1:0] reg_sel;
    logic       tick;
    logic       set_ovf;
    logic       set_udf;

    logic tcr_load;
    logic tcr_down;
    logic tcr_en;

    assign access    = apb.psel & apb.penable;
    assign addr_ok   = (apb.paddr[ADDR_W-1:2] == '0);
    assign reg_sel   = apb.paddr[1:0];
    assign wr_commit = access & apb.pwrite & addr_ok;

    assign tcr_load  = tcr_q[7];
    assign tcr_down  = tcr_q[5];
    assign tcr_en    = tcr_q[4];

    always_comb begin
        case (tcr_q[1:0])
            2'd0:    presc_max = 4'd1;
            2'd1:    presc_max = 4'd3;
            2'd2:    presc_max = 4'd7;
            default: presc_max = 4'd15;
        endcase
    end

    // Compare with >= so shrinking CKS mid-count fires on the next cycle instead of wrapping the prescaler.
    always_comb begin
        presc_d = presc_q;
        tcnt_d  = tcnt_q;
        tick    = 1'b0;
        set_ovf = 1'b0;
        set_udf = 1'b0;
        if (tcr_load) begin
            presc_d = '0;
            tcnt_d  = tdr_q;
        end else if (tcr_en) begin
            if (presc_q >= presc_max) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + 4'd1;
            end
        end else begin
            presc_d = '0;
        end

        if (tick) begin
            if (tcr_down) begin
                set_udf = (tcnt_q == '0);
                tcnt_d  = tcnt_q - 1'b1;
            end else begin
                set_ovf = (tcnt_q == '1);
                tcnt_d  = tcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        tdr_d = tdr_q;
        tcr_d = tcr_q;
        tsr_d = tsr_q;
        if (wr_commit) begin
            case (reg_sel)
                A_TDR:   tdr_d = apb.pwdata;
                A_TCR:   tcr_d = apb.pwdata & TCR_MASK;
                A_TSR:   tsr_d = tsr_q & apb.pwdata[1:0];
                default: ;
            endcase
        end
        // Hardware set is applied after the software clear so a same-edge wrap keeps the flag.
        tsr_d = tsr_d | {set_udf, set_ovf};
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            tdr_q   <= '0;
            tcr_q   <= '0;
            tsr_q   <= '0;
            tcnt_q  <= '0;
            presc_q <= '0;
        end else begin
            tdr_q   <= tdr_d;
            tcr_q   <= tcr_d;
            tsr_q   <= tsr_d;
            tcnt_q  <= tcnt_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        case (reg_sel)
            A_TDR:   rd_mux = tdr_q;
            A_TCR:   rd_mux = tcr_q;
            A_TSR:   rd_mux = {{(CNT_W-2){1'b0}}, tsr_q};
            default: rd_mux = tcnt_q;
        endcase
    end

    // Outputs are forced quiet while reset is held, before the first reset edge clears the state.
    assign apb.prdata  = (presetn && access && !apb.pwrite && addr_ok) ? rd_mux : '0;
    assign apb.pslverr = presetn & access & (!addr_ok | (apb.pwrite & (reg_sel == A_TCNT)));
    assign apb.pready  = 1'b1;
    assign tmr_ovf     = presetn & tsr_q[0];
    assign tmr_udf     = presetn & tsr_q[1];
endmodule

// File: tb/tb_timer_apb_regs.sv
// Bench for timer_apb_regs: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_timer_apb_regs;
    logic pclk    = 1'b0;
    logic presetn = 1'b0;
    logic tmr_ovf;
    logic tmr_udf;

    int checks      = 0;
    int failures    = 0;
    int cyc         = 0;
    int last_commit = 0;

    timer_apb_regs_if #(.ADDR_W(8), .CNT_W(8)) apb ();

    timer_apb_regs #(.ADDR_W(8), .CNT_W(8)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .apb     (apb),
        .tmr_ovf (tmr_ovf),
        .tmr_udf (tmr_udf)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    // Reference model: register contents as integers, counting advanced by "cycles since last tick".
    int m_tdr = 0, m_tcr = 0, m_tsr = 0, m_cnt = 0, m_since = 0;

    always @(posedge pclk) begin : model
        int  div;
        int  a;
        int  nxt_tsr;
        bit  wrap_up;
        bit  wrap_dn;
        bit  wr;
        if (!presetn) begin
            m_tdr = 0; m_tcr = 0; m_tsr = 0; m_cnt = 0; m_since = 0;
        end else begin
            a       = int'(apb.paddr);
            wr      = apb.psel && apb.penable && apb.pwrite;
            wrap_up = 1'b0;
            wrap_dn = 1'b0;
            nxt_tsr = m_tsr;
            if (m_tcr[7]) begin
                m_cnt   = m_tdr;
                m_since = 0;
            end else if (m_tcr[4]) begin
                div = 2 << m_tcr[1:0];
                if (m_since + 1 >= div) begin
                    m_since = 0;
                    if (m_tcr[5]) begin
                        wrap_dn = (m_cnt == 0);
                        m_cnt   = (m_cnt + 255) % 256;
                    end else begin
                        wrap_up = (m_cnt == 255);
                        m_cnt   = (m_cnt + 1) % 256;
                    end
                end else begin
                    m_since = m_since + 1;
                end
            end else begin
                m_since = 0;
            end
            if (wr && a == 0) m_tdr = int'(apb.pwdata);
            if (wr && a == 1) m_tcr = int'(apb.pwdata) & 'hB3;
            if (wr && a == 2) nxt_tsr = m_tsr & int'(apb.pwdata);
            m_tsr = nxt_tsr | (wrap_up ? 1 : 0) | (wrap_dn ? 2 : 0);
        end
    end

    function automatic int model_rd(input int a);
        case (a)
            0:       return m_tdr;
            1:       return m_tcr;
            2:       return m_tsr;
            3:       return m_cnt;
            default: return 0;
        endcase
    endfunction

    task automatic apb_write(input logic [7:0] a, input logic [7:0] d, output logic e);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = a; apb.pwdata = d;
        @(negedge pclk);
        apb.penable = 1'b1;
        #1;
        e = apb.pslverr;
        @(negedge pclk);
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        last_commit = cyc;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [7:0] d, output logic e,
                            output logic o, output logic u, output int xd, output int xt);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = a;
        @(negedge pclk);
        apb.penable = 1'b1;
        #1;
        d  = apb.prdata;
        e  = apb.pslverr;
        o  = tmr_ovf;
        u  = tmr_udf;
        xd = model_rd(int'(a));
        xt = m_tsr;
        @(negedge pclk);
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    // Access phase lands between posedge k and k+1.
    task automatic read_at(input logic [7:0] a, input int k, output logic [7:0] d,
                           output logic e, output logic o, output logic u);
        int xd, xt;
        checks++;
        if (cyc > k - 1) begin
            failures++;
            $display("FAIL read_at_late: cyc=%0d needed=%0d", cyc, k - 1);
        end
        while (cyc < k - 1) @(negedge pclk);
        apb_read(a, d, e, o, u, xd, xt);
    endtask

    task automatic test_reset();
        logic [7:0] d; logic e, o, u; int xd, xt;
        presetn = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        apb.psel = 1'b1; apb.penable = 1'b1; apb.pwrite = 1'b0; apb.paddr = 8'h07;
        #1;
        checks++;
        if (apb.pslverr !== 1'b0 || apb.prdata !== 8'h00 || apb.pready !== 1'b1) begin
            failures++;
            $display("FAIL reset_outputs: pslverr=%b prdata=%h pready=%b want 0/00/1",
                     apb.pslverr, apb.prdata, apb.pready);
        end
        @(negedge pclk);
        apb.psel = 1'b0; apb.penable = 1'b0;
        presetn = 1'b1;
        for (int a = 0; a < 4; a++) begin
            apb_read(8'(a), d, e, o, u, xd, xt);
            checks++;
            if (d !== 8'h00 || e !== 1'b0 || o !== 1'b0 || u !== 1'b0) begin
                failures++;
                $display("FAIL reset_read[%0d]: data=%h err=%b ovf=%b udf=%b want 00/0/0/0", a, d, e, o, u);
            end
        end
    endtask

    task automatic test_load();
        logic [7:0] d; logic e, o, u; int xd, xt;
        apb_write(8'h00, 8'h79, e);
        apb_write(8'h01, 8'h80, e);
        apb_read(8'h03, d, e, o, u, xd, xt);
        checks++;
        if (d !== 8'h79) begin failures++; $display("FAIL load_tcnt: got %h want 79", d); end
        apb_read(8'h01, d, e, o, u, xd, xt);
        checks++;
        if (d !== 8'h80) begin failures++; $display("FAIL load_tcr: got %h want 80", d); end
        apb_write(8'h01, 8'hFF, e);
        apb_read(8'h01, d, e, o, u, xd, xt);
        checks++;
        if (d !== 8'hB3) begin failures++; $display("FAIL tcr_mask: got %h want b3", d); end
        apb_write(8'h00, 8'hFE, e);
        apb_write(8'h01, 8'h80, e);
        repeat (100) @(negedge pclk);
        apb_read(8'h02, d, e, o, u, xd, xt);
        checks++;
        if (d !== 8'h00 || o !== 1'b0) begin failures++; $display("FAIL load_no_flags: tsr=%h ovf=%b want 00/0", d, o); end
        apb_read(8'h03, d, e, o, u, xd, xt);
        checks++;
        if (d !== 8'hFE) begin failures++; $display("FAIL load_hold: tcnt=%h want fe", d); end
    endtask

    task automatic test_up_count();
        logic [7:0] d; logic e, o, u; int c0;
        apb_write(8'h00, 8'hFE, e);
        apb_write(8'h01, 8'h80, e);
        apb_write(8'h01, 8'h11, e);
        c0 = last_commit;
        read_at(8'h03, c0 + 4, d, e, o, u);
        checks++;
        if (d !== 8'hFF) begin failures++; $display("FAIL up_first_tick: tcnt=%h want ff", d); end
        read_at(8'h03, c0 + 6, d, e, o, u);
        checks++;
        if (d !== 8'hFF || o !== 1'b0) begin failures++; $display("FAIL up_hold: tcnt=%h ovf=%b want ff/0", d, o); end
        read_at(8'h03, c0 + 8, d, e, o, u);
        checks++;
        if (d !== 8'h00 || o !== 1'b1) begin failures++; $display("FAIL up_wrap: tcnt=%h ovf=%b want 00/1", d, o); end
        read_at(8'h02, c0 + 10, d, e, o, u);
        checks++;
        if (d !== 8'h01 || o !== 1'b1 || u !== 1'b0) begin
            failures++; $display("FAIL up_tsr: tsr=%h ovf=%b udf=%b want 01/1/0", d, o, u);
        end
    endtask

    task automatic test_down_count();
        logic [7:0] d; logic e, o, u; int c0;
        apb_write(8'h01, 8'h00, e);
        apb_write(8'h00, 8'h01, e);
        apb_write(8'h01, 8'h80, e);
        apb_write(8'h01, 8'h30, e);
        c0 = last_commit;
        read_at(8'h03, c0 + 2, d, e, o, u);
        checks++;
        if (d !== 8'h00 || u !== 1'b0) begin failures++; $display("FAIL down_first: tcnt=%h udf=%b want 00/0", d, u); end
        read_at(8'h03, c0 + 4, d, e, o, u);
        checks++;
        if (d !== 8'hFF || u !== 1'b1) begin failures++; $display("FAIL down_wrap: tcnt=%h udf=%b want ff/1", d, u); end
        read_at(8'h02, c0 + 6, d, e, o, u);
        checks++;
        if (d !== 8'h03 || o !== 1'b1 || u !== 1'b1) begin
            failures++; $display("FAIL down_tsr: tsr=%h ovf=%b udf=%b want 03/1/1", d, o, u);
        end
    endtask

    task automatic test_flag_clear();
        logic [7:0] d; logic e, o, u; int xd, xt, c0;
        apb_write(8'h01, 8'h00, e);
        apb_write(8'h02, 8'h02, e);
        apb_read(8'h02, d, e, o, u, xd, xt);
        checks++;
        if (d !== 8'h02 || o !== 1'b0 || u !== 1'b1) begin
            failures++; $display("FAIL tsr_partial_clear: tsr=%h ovf=%b udf=%b want 02/0/1", d, o, u);
        end
        apb_write(8'h02, 8'h00, e);
        apb_read(8'h02, d, e, o, u, xd, xt);
        checks++;
        if (d !== 8'h00 || u !== 1'b0) begin failures++; $display("FAIL tsr_clear: tsr=%h udf=%b want 00/0", d, u); end
        apb_write(8'h00, 8'hFF, e);
        apb_write(8'h01, 8'h80, e);
        apb_write(8'h01, 8'h10, e);
        c0 = last_commit;
        apb_write(8'h02, 8'h00, e);
        checks++;
        if (last_commit !== c0 + 2) begin
            failures++; $display("FAIL clear_edge_align: commit=%0d want %0d", last_commit, c0 + 2);
        end
        apb_read(8'h02, d, e, o, u, xd, xt);
        checks++;
        if (d !== 8'h01 || o !== 1'b1) begin failures++; $display("FAIL set_beats_clear: tsr=%h ovf=%b want 01/1", d, o); end
        apb_write(8'h01, 8'h00, e);
    endtask

    task automatic test_errors();
        logic [7:0] d, snap; logic e, o, u; int xd, xt;
        logic [7:0] exp_v [4];
        apb_read(8'h03, snap, e, o, u, xd, xt);
        exp_v[0] = 8'hFF; exp_v[1] = 8'h00; exp_v[2] = 8'h01; exp_v[3] = snap;
        apb_write(8'h03, 8'h55, e);
        checks++;
        if (e !== 1'b1) begin failures++; $display("FAIL err_wr_tcnt: pslverr=%b want 1", e); end
        apb_write(8'h07, 8'h55, e);
        checks++;
        if (e !== 1'b1) begin failures++; $display("FAIL err_wr_07: pslverr=%b want 1", e); end
        apb_write(8'h41, 8'h55, e);
        checks++;
        if (e !== 1'b1) begin failures++; $display("FAIL err_wr_41: pslverr=%b want 1", e); end
        for (int a = 0; a < 4; a++) begin
            apb_read(8'(a), d, e, o, u, xd, xt);
            checks++;
            if (d !== exp_v[a] || e !== 1'b0) begin
                failures++; $display("FAIL err_no_change[%0d]: data=%h err=%b want %h/0", a, d, e, exp_v[a]);
            end
        end
        apb_read(8'h07, d, e, o, u, xd, xt);
        checks++;
        if (d !== 8'h00 || e !== 1'b1) begin failures++; $display("FAIL err_rd_07: data=%h err=%b want 00/1", d, e); end
        apb_read(8'h42, d, e, o, u, xd, xt);
        checks++;
        if (d !== 8'h00 || e !== 1'b1) begin failures++; $display("FAIL err_rd_42: data=%h err=%b want 00/1", d, e); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d; logic e, o, u; int xd, xt;
        apb_write(8'h00, 8'hFF, e);
        apb_write(8'h01, 8'h80, e);
        apb_write(8'h01, 8'h10, e);
        repeat (4) @(negedge pclk);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 8'h00; apb.pwdata = 8'hAA;
        presetn = 1'b0;
        #1;
        checks++;
        if (tmr_ovf !== 1'b0 || apb.pready !== 1'b1) begin
            failures++; $display("FAIL reset_mid_outputs: ovf=%b pready=%b want 0/1", tmr_ovf, apb.pready);
        end
        @(negedge pclk);
        apb.penable = 1'b1;
        @(negedge pclk);
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        presetn = 1'b1;
        for (int a = 0; a < 4; a++) begin
            apb_read(8'(a), d, e, o, u, xd, xt);
            checks++;
            if (d !== 8'h00 || o !== 1'b0) begin
                failures++; $display("FAIL reset_mid_read[%0d]: data=%h ovf=%b want 00/0", a, d, o);
            end
        end
        apb_write(8'h00, 8'h5A, e);
        apb_read(8'h00, d, e, o, u, xd, xt);
        checks++;
        if (d !== 8'h5A || e !== 1'b0) begin failures++; $display("FAIL post_reset_access: data=%h err=%b want 5a/0", d, e); end
    endtask

    task automatic test_random();
        logic [7:0] d, a, wd; logic e, o, u; int xd, xt, op;
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                a  = 8'($urandom_range(0, 2));
                wd = 8'($urandom);
                if (a == 8'h01) begin
                    wd[7] = ($urandom_range(0, 3) == 0);
                    wd[4] = ($urandom_range(0, 3) != 0);
                end
                if (a == 8'h02 && $urandom_range(0, 1) == 1) wd[1:0] = 2'b11;
                if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 1) ? 8'h03 : (8'h20 | a);
                apb_write(a, wd, e);
                checks++;
                if (e !== ((a > 8'h03) || (a == 8'h03))) begin
                    failures++; $display("FAIL rnd_wr_err: addr=%h err=%b", a, e);
                end
            end else if (op <= 7) begin
                a = 8'($urandom_range(0, 7));
                if ($urandom_range(0, 7) == 0) a = a | 8'h80;
                apb_read(a, d, e, o, u, xd, xt);
                checks++;
                if (d !== 8'(xd) || e !== (a > 8'h03) || o !== xt[0] || u !== xt[1]) begin
                    failures++;
                    $display("FAIL rnd_rd: addr=%h data=%h err=%b ovf=%b udf=%b want %h/%b/%b/%b",
                             a, d, e, o, u, 8'(xd), (a > 8'h03), xt[0], xt[1]);
                end
            end else begin
                repeat ($urandom_range(1, 24)) @(negedge pclk);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
        @(negedge pclk);
        test_reset();
        test_load();
        test_up_count();
        test_down_count();
        test_flag_clear();
        test_errors();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/timer_apb_regs.md
Name: timer_apb_regs

Overview:
- APB3 completer (responder) for the 8-bit timer.
- Serves CPU bus-model reads and writes to the timer registers:
  - TDR: reload data.
  - TCR: control.
  - TSR: status.
  - TCNT: live count.
- Contains the prescaled up/down counter, and raises sticky overflow/underflow flags as level interrupt outputs.
- Sits between the system APB fabric and the interrupt handler.

Parameters:
ADDR_W, 8, width of paddr; only bits [1:0] decode, upper bits must be zero for a valid access
CNT_W, 8, counter/register data width (fixed 8 for this revision)

Ports:
pclk  in  1  system clock; all logic rising-edge
presetn  in  1  synchronous active-low reset, sampled on pclk rising edge
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  1=write, 0=read
paddr  in  ADDR_W  register address
pwdata  in  CNT_W  write data
prdata  out  CNT_W  read data, valid when psel&penable&!pwrite
pready  out  1  tied 1 (zero wait states)
pslverr  out  1  error response, valid in access phase
tmr_ovf  out  1  = TSR[0]
tmr_udf  out  1  = TSR[1]

Behaviour:
- Reset (presetn=0 at clock edge): TDR=0x00, TCR=0x00, TSR=0x00, TCNT=0x00, prescaler=0.
  - Outputs during reset: prdata=0, pslverr=0, tmr_ovf=0, tmr_udf=0, pready=1.
  - Reset mid-count or mid-transfer aborts everything; the first post-reset access must complete normally.
- Register map:
  - 0x00 TDR: RW.
  - 0x01 TCR: RW.
    - Bit 7 = LOAD.
    - Bit 5 = DOWN (0 up, 1 down).
    - Bit 4 = EN.
    - Bits [1:0] = CKS.
    - Bits 6, 3, 2 read 0 and ignore writes.
  - 0x02 TSR: bit0 OVF, bit1 UDF; other bits read 0.
  - 0x03 TCNT: read-only.
- APB:
  - Write commits on the cycle where psel&penable&pwrite=1; no effect in the setup phase.
  - Read data is combinational from current register state in the access phase; prdata=0 otherwise.
  - pslverr=1 in the access phase for:
    - paddr > 0x03, where reads return 0x00 and writes are ignored;
    - a write to 0x03, which is ignored.
- TSR write: write-0-to-clear per bit. Bits written 1 keep their value; writing 0x00 clears both.
  - A hardware set in the same cycle as a software clear wins: the flag stays 1.
- LOAD: while TCR[7]=1, TCNT<=TDR every cycle, the prescaler is held at 0, and counting and flag setting are suppressed, regardless of EN.
- Prescaler:
  - Divisor N selected by CKS: 00→2, 01→4, 10→8, 11→16.
  - When EN=1 and LOAD=0, the prescaler increments each pclk.
  - When the prescaler ≥ N-1, a tick fires and the prescaler returns to 0. Using ≥ means a CKS change mid-count never stalls.
  - EN=0 holds the prescaler at 0 and TCNT frozen.
- Count on tick:
  - Up: TCNT+1. At 0xFF it wraps to 0x00 and sets TSR[0] in the same edge.
  - Down: TCNT-1. At 0x00 it wraps to 0xFF and sets TSR[1].
  - Modulo 2^8, no saturation.
- First tick lands N pclk after the write that sets EN=1 (with LOAD=0).
- A TCR write that changes DIR takes effect from the next tick; the prescaler is not reset.
- A TDR write does not disturb TCNT unless LOAD=1.
- Flags are sticky until cleared by software or reset; further wraps while set leave them set.

Test Plan:
- Reset/defaults: apply presetn=0 for 3 cycles, then read 0x00–0x03 → all 0x00, pslverr=0, tmr_ovf=tmr_udf=0.
- Load path:
  - Write TDR=0x79, then TCR=0x80 → next read of TCNT = 0x79.
  - Read TCR → 0x80.
  - Write TCR=0xFF → read back 0xB3.
- Up count, CKS=01 (/4):
  - Write TDR=0xFE, TCR=0x80, then TCR=0x11.
  - TCNT=0xFF 4 pclk after the EN write; 0x00 at 8 pclk, with TSR=0x01 and tmr_ovf=1.
  - Poll at 100 pclk after loading 0x80 → TSR=0x00.
- Down count, CKS=00 (/2):
  - Write TDR=0x01, TCR=0x80, then TCR=0x30.
  - TCNT=0x00 at 2 pclk, 0xFF at 4 pclk, TSR=0x02, tmr_udf=1, TSR[0] unchanged.
- Flag clear and priority:
  - Write TSR=0x00 → TSR=0x00.
  - Write TSR=0x02 with both set → TSR=0x02.
  - Arrange a clear on the exact wrap edge → flag reads 1.
- Errors: write 0x55 to 0x03 and to 0x07 → pslverr=1, no register changes; read 0x07 → 0x00 with pslverr=1.
